// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Owns the PC, issues one word read at a time to instruction memory and
// buffers returned words in a small queue. Redirects flush the queue and
// cause any in-flight response to be discarded.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets in a sticky FAULT state (left only through reset_n).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until the transfer,
// except that a redirect may replace the request address. Memory responses
// carry no ready; a queue slot is reserved when the request is accepted.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [31:0]        q_data_q [DEPTH];
  logic [31:0]        q_data_d [DEPTH];
  logic [31:0]        q_pc_q   [DEPTH];
  logic [31:0]        q_pc_d   [DEPTH];

  logic               req_fire;
  logic               resp_take;
  logic               redir_act;
  logic               misalign;
  logic               push;
  logic               pop;
  logic               outstanding;
  logic [CNT_W:0]     used_slots;
  logic [PTR_W-1:0]   tail;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = (state_q == S_FAULT);
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Shared handshake and bookkeeping terms.
  assign outstanding = (state_q == S_WAIT);
  assign used_slots  = {1'b0, count_q} + (CNT_W + 1)'(outstanding);
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign resp_take   = (state_q == S_WAIT) && imem_resp_valid;
  assign redir_act   = redirect_valid && (state_q != S_FAULT);
  assign push        = resp_take && !drop_q && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign tail        = head_q + count_q[PTR_W-1:0];

  assign imem_req_addr = pc_q;
  assign instr_valid   = (count_q != '0);
  assign instr         = q_data_q[head_q];
  assign instr_pc      = q_pc_q[head_q];
  assign dbg_state     = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: normal fetch loop, overridden by redirects.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (imem_resp_valid) state_d = S_REQ;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (redir_act) begin
      if (misalign) begin
        state_d = S_FAULT;
      end else if ((state_q == S_WAIT) && !imem_resp_valid) begin
        state_d = S_WAIT;
      end else if (req_fire) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  // FSM outputs: request only while no response is owed and a slot is free.
  always_comb begin
    imem_req_valid = 1'b0;
    if ((state_q == S_REQ) && (used_slots < (CNT_W + 1)'(DEPTH))) begin
      imem_req_valid = 1'b1;
    end
  end

  // PC, request tag and drop flag next-state.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    if (req_fire) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
    if (resp_take) begin
      drop_d = 1'b0;
    end
    if (redir_act) begin
      pc_d = redirect_pc;
      // A response is still owed for a request that predates the redirect.
      if (!misalign && (((state_q == S_WAIT) && !imem_resp_valid) || req_fire)) begin
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b0;
      end
    end
  end

  // Instruction queue next-state: push at tail, pop at head, flush on redirect.
  always_comb begin
    q_data_d = q_data_q;
    q_pc_d   = q_pc_q;
    head_d   = head_q;
    count_d  = count_q;
    if (push) begin
      q_data_d[tail] = imem_resp_data;
      q_pc_d[tail]   = req_pc_q;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (redir_act) begin
      count_d = '0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      head_q   <= head_d;
      q_data_q <= q_data_d;
      q_pc_q   <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit with a behavioural memory, a
// stream-level reference model and scenario tables.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .fetch_fault     (fetch_fault),
    .dbg_state       (dbg_state)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  // memory model
  bit          pending;
  int          pend_cnt;
  logic [31:0] pend_addr;
  // stream model: next PC decode must see, next PC memory must be asked for
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  bit          faulted;
  // previous-cycle observations
  bit          redir_prev;
  logic [31:0] redir_prev_tgt;
  bit          reqv_prev;
  bit          acc_prev;
  logic [31:0] reqaddr_prev;
  // knobs
  int          lat_cfg;
  int          rdy_pct;
  int          dec_pct;
  int          rand_redir_pct;
  int          trig_mode;
  logic [31:0] trig_tgt;
  bit          trig_done;
  // logs
  logic [31:0] seen_q[$];
  logic [31:0] req_log[$];
  logic [31:0] exp_q[$];
  int          n_cons;

  typedef struct {
    int          lat;
    int          mode;   // 0 outstanding, 1 with resp+consume, 2 with req handshake, 3 immediate
    logic [31:0] tgt;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Queue must never pop when empty or push when full.
  always @(posedge clk) begin
    if (reset_n) begin
      if (dut.pop && (dut.count_q == 2'd0)) begin
        errors++;
        $display("FAIL queue_pop_empty: got pop with count 0 expected no pop");
      end
      if (dut.push && (dut.count_q == 2'd2)) begin
        errors++;
        $display("FAIL queue_push_full: got push with count 2 expected no push");
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge: check outputs, drive inputs, advance models.
  task automatic cycle();
    bit          rsp, hs, cons, rdr;
    logic [31:0] tgt;
    if (redir_prev) begin
      check1("instr_valid_after_redirect", instr_valid, 1'b0);
      if (imem_req_valid && !faulted)
        check32("req_addr_after_redirect", imem_req_addr, redir_prev_tgt);
    end
    if (reqv_prev && !acc_prev && !redir_prev && !faulted) begin
      check1("req_valid_held", imem_req_valid, 1'b1);
      check32("req_addr_stable", imem_req_addr, reqaddr_prev);
    end
    check1("fetch_fault", fetch_fault, faulted);
    if (faulted) begin
      check1("fault_no_req", imem_req_valid, 1'b0);
      check1("fault_no_instr", instr_valid, 1'b0);
    end

    rsp = pending && (pend_cnt == 0);
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mem_word(pend_addr) : $urandom();
    imem_req_ready  = ($urandom_range(99) < rdy_pct);
    instr_ready     = ($urandom_range(99) < dec_pct);
    rdr = 1'b0;
    tgt = '0;
    if ((trig_mode >= 0) && !trig_done) begin
      case (trig_mode)
        0: rdr = pending && (pend_cnt > 0);
        1: if (rsp && instr_valid) begin rdr = 1'b1; instr_ready = 1'b1; end
        2: if (imem_req_valid) begin rdr = 1'b1; imem_req_ready = 1'b1; end
        default: rdr = 1'b1;
      endcase
      if (rdr) begin
        tgt = trig_tgt;
        trig_done = 1'b1;
      end
    end else if ((rand_redir_pct > 0) && ($urandom_range(99) < rand_redir_pct)) begin
      rdr = 1'b1;
      tgt = $urandom() & 32'hFFFF_FFFC;
    end
    redirect_valid = rdr;
    redirect_pc    = rdr ? tgt : $urandom();

    hs   = imem_req_valid && imem_req_ready;
    cons = instr_valid && instr_ready;
    if (cons) begin
      check32("instr_pc", instr_pc, exp_pc);
      check32("instr_data", instr, mem_word(exp_pc));
      seen_q.push_back(instr_pc);
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    if (hs) begin
      check32("req_addr_seq", imem_req_addr, exp_req);
      if (pending && !rsp) begin
        errors++;
        $display("FAIL one_outstanding: got second request at 0x%08h expected none", imem_req_addr);
      end
      req_log.push_back(imem_req_addr);
      exp_req = exp_req + 32'd4;
    end
    if (rdr) begin
      exp_pc  = tgt;
      exp_req = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) faulted = 1'b1;
`endif
    end

    if (rsp) pending = 1'b0;
    else if (pending) pend_cnt--;
    if (hs) begin
      pending   = 1'b1;
      pend_addr = imem_req_addr;
      pend_cnt  = (lat_cfg == 0) ? int'($urandom_range(3, 0)) : lat_cfg - 1;
    end

    redir_prev     = rdr;
    redir_prev_tgt = tgt;
    reqv_prev      = imem_req_valid;
    acc_prev       = hs;
    reqaddr_prev   = imem_req_addr;
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge of reset release.
  task automatic do_reset(input bit check_async);
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    instr_ready     = 1'b0;
    if (check_async) begin
      #1;
      check1("async_req_valid", imem_req_valid, 1'b0);
      check32("async_req_addr", imem_req_addr, RST_PC);
      check1("async_instr_valid", instr_valid, 1'b0);
      check32("async_instr", instr, 32'h0);
      check32("async_instr_pc", instr_pc, 32'h0);
      check1("async_fetch_fault", fetch_fault, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    pending  = 1'b0;
    pend_cnt = 0;
    exp_pc   = RST_PC;
    exp_req  = RST_PC;
    faulted  = 1'b0;
    redir_prev = 1'b0;
    reqv_prev  = 1'b0;
    acc_prev   = 1'b0;
    trig_mode  = -1;
    seen_q.delete();
    req_log.delete();
    check1("reset_req_valid_idle", imem_req_valid, 1'b0);
    check32("reset_req_addr", imem_req_addr, RST_PC);
    check1("reset_instr_valid", instr_valid, 1'b0);
    check1("reset_fetch_fault", fetch_fault, 1'b0);
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (seen_q.size() > i) ? seen_q[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 32'hFFFF_FFFF;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    int   viol;
    reset_n        = 1'b0;
    lat_cfg        = 1;
    rdy_pct        = 100;
    dec_pct        = 100;
    rand_redir_pct = 0;
    trig_mode      = -1;
    trig_done      = 1'b0;
    n_cons         = 0;
    redirect_pc    = '0;
    imem_resp_data = '0;

    v = '{lat: 3, mode: 0, tgt: 32'h0040_0100, exp_first: 32'h0040_0100, exp_second: 32'h0040_0104};
    vecs.push_back(v);
    v = '{lat: 1, mode: 1, tgt: 32'h0040_0200, exp_first: 32'h0040_0200, exp_second: 32'h0040_0204};
    vecs.push_back(v);
    v = '{lat: 1, mode: 2, tgt: 32'h0040_0300, exp_first: 32'h0040_0300, exp_second: 32'h0040_0304};
    vecs.push_back(v);
    v = '{lat: 2, mode: 0, tgt: 32'hFFFF_FFFC, exp_first: 32'hFFFF_FFFC, exp_second: 32'h0000_0000};
    vecs.push_back(v);
    v = '{lat: 1, mode: 3, tgt: 32'h0000_1000, exp_first: 32'h0000_1000, exp_second: 32'h0000_1004};
    vecs.push_back(v);
`ifndef FETCH_ALIGN_CHECK_EN
    v = '{lat: 1, mode: 3, tgt: 32'h0040_0102, exp_first: 32'h0040_0102, exp_second: 32'h0040_0106};
    vecs.push_back(v);
`endif

    @(negedge clk);
    do_reset(1'b1);

    // Straight-line fetch with 1-cycle memory and a always-ready decoder.
    for (int i = 0; i < 40 && seen_q.size() < 3; i++) cycle();
    check32("t1_first_req", req_at(0), RST_PC);
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    exp_q.push_back(32'h0040_0008);
    for (int i = 0; i < 3; i++) check32("t1_pc_seq", seen_at(i), exp_q.pop_front());

    // Decoder stalled for 10 cycles: exactly two words queued.
    do_reset(1'b0);
    dec_pct = 0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if ((req_log.size() >= 2) && imem_req_valid) viol++;
      cycle();
    end
    check32("t2_accepted", 32'(req_log.size()), 32'd2);
    check32("t2_req_after_full", 32'(viol), 32'd0);
    check1("t2_req_valid_low", imem_req_valid, 1'b0);
    check1("t2_instr_valid", instr_valid, 1'b1);
    dec_pct = 100;
    for (int i = 0; i < 40 && seen_q.size() < 3; i++) cycle();
    exp_q.push_back(32'h0040_0000);
    exp_q.push_back(32'h0040_0004);
    exp_q.push_back(32'h0040_0008);
    for (int i = 0; i < 3; i++) check32("t2_pc_order", seen_at(i), exp_q.pop_front());

    // Redirect scenario table.
    foreach (vecs[k]) begin
      lat_cfg   = vecs[k].lat;
      dec_pct   = (vecs[k].mode == 1) ? 30 : 100;
      rdy_pct   = 100;
      trig_mode = vecs[k].mode;
      trig_tgt  = vecs[k].tgt;
      trig_done = 1'b0;
      for (int i = 0; i < 200 && !trig_done; i++) cycle();
      check1("tbl_trigger", trig_done, 1'b1);
      trig_mode = -1;
      seen_q.delete();
      req_log.delete();
      dec_pct = 100;
      for (int i = 0; i < 200 && seen_q.size() < 2; i++) cycle();
      check32("tbl_first_req", req_at(0), vecs[k].exp_first);
      check32("tbl_first_pc", seen_at(0), vecs[k].exp_first);
      check32("tbl_second_pc", seen_at(1), vecs[k].exp_second);
    end

    // Asynchronous reset in the middle of a stream.
    lat_cfg = 1;
    dec_pct = 0;
    repeat (8) cycle();
    check1("t4_queue_loaded", instr_valid, 1'b1);
    do_reset(1'b1);
    dec_pct = 100;
    for (int i = 0; i < 40 && seen_q.size() < 1; i++) cycle();
    check32("t4_restart_req", req_at(0), RST_PC);
    check32("t4_restart_pc", seen_at(0), RST_PC);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect traps until reset.
    repeat (5) cycle();
    trig_mode = 3;
    trig_tgt  = 32'h0040_0102;
    trig_done = 1'b0;
    cycle();
    trig_mode = -1;
    req_log.delete();
    check1("t5_fault_next_cycle", fetch_fault, 1'b1);
    repeat (20) cycle();
    check32("t5_no_requests", 32'(req_log.size()), 32'd0);
    check1("t5_fault_held", fetch_fault, 1'b1);
    do_reset(1'b1);
    for (int i = 0; i < 40 && seen_q.size() < 1; i++) cycle();
    check32("t5_restart_pc", seen_at(0), RST_PC);
`endif

    // Randomized traffic against the stream model.
    do_reset(1'b0);
    lat_cfg        = 0;
    rdy_pct        = 70;
    dec_pct        = 60;
    rand_redir_pct = 5;
    n_cons         = 0;
    repeat (3000) cycle();
    check1("rand_progress", n_cons > 100, 1'b1);
    check1("rand_fault_low", fetch_fault, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction decoder/control block. It owns the program counter, issues word reads to instruction memory over a request/response handshake, and buffers returned words in a 2-entry queue. It presents `{instr, instr_pc}` to decode with a valid/ready handshake. Jump/branch redirects from downstream flush the queue and discard any in-flight response.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset (MIPS text base).
- `DEPTH`, default 2: instruction queue entries; legal values are 2 only, fixed.
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `imem_req_valid`  out  1: read request valid.
- `imem_req_addr`  out  32: word address of the request; always equal to current `pc`.
- `imem_req_ready`  in  1: memory accepts the request this cycle.
- `imem_resp_valid`  in  1: read data valid; may arrive 1 or more cycles after acceptance; cannot be back-pressured.
- `imem_resp_data`  in  32: instruction word.
- `redirect_valid`  in  1: jump/branch taken; load `redirect_pc`.
- `redirect_pc`  in  32: target PC.
- `instr_valid`  out  1: queue head is valid.
- `instr`  out  32: instruction word at the queue head.
- `instr_pc`  out  32: PC of `instr`.
- `instr_ready`  in  1: decode consumes the queue head.
- `fetch_fault`  out  1: misaligned redirect. Only exists with `FETCH_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- States:
  - IDLE: one cycle after reset release, then to REQ.
  - REQ: drive `imem_req_valid` when `count + outstanding < 2`.
  - WAIT: one request outstanding.
  - FAULT: only with the macro.
- Only one request is outstanding at a time. A queue slot is reserved at acceptance, so a response always has space.
- REQ → WAIT on `imem_req_valid & imem_req_ready`. At that edge `pc <= pc + 4` (wraps mod 2^32) and `req_pc <= pc`.
- WAIT → REQ on `imem_resp_valid`. If the drop flag is clear, push `{imem_resp_data, req_pc}`. If set, discard the response and clear the flag.
- Redirect (any state except FAULT):
  - `pc <= redirect_pc`.
  - Queue flushed (count = 0).
  - In WAIT without a same-cycle response, set the drop flag and stay in WAIT.
  - Otherwise go to REQ.
- Redirect beats a same-cycle response: the response is discarded and the drop flag stays clear.
- Redirect beats a same-cycle request handshake: the request is issued with the old PC, `pc <= redirect_pc`, state → WAIT, drop flag set.
- Redirect with a same-cycle `instr_valid & instr_ready`: the consume is honoured (decode took it), then flushed.
- Queue push and pop in the same cycle: count unchanged, order preserved. Pop on empty or push on full cannot occur by construction. Verification asserts both.
- `imem_req_addr` and `instr_pc` are full 32-bit values; the low 2 bits pass through unmodified.

## Timing
- Reset values: `pc = RESET_PC`, state IDLE, count 0, drop 0.
- Output reset values: `imem_req_valid = 0`, `imem_req_addr = RESET_PC`, `instr_valid = 0`, `instr = 0`, `instr_pc = 0`, `fetch_fault = 0`.
- Reset is asynchronous. Assertion mid-operation clears everything immediately. Responses arriving after reset release that belong to pre-reset requests are outside the contract.
- `imem_req_valid` is combinational from state/count. It is held with a stable address until accepted, unless a redirect changes `pc`.
- Latency: a response in cycle N makes `instr_valid` high in N+1. A request can issue in cycle N+1 if space allows.
- Throughput: 1 instruction per 2 cycles with 1-cycle memory.
- Redirect in cycle N: `imem_req_valid` with `imem_req_addr = redirect_pc` no earlier than N+1. `instr_valid = 0` in N+1.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` enters FAULT.
  - Queue flushed, `fetch_fault = 1` from the next cycle.
  - No further requests; in-flight response discarded.
  - Leave FAULT only via `reset_n`.
- `FETCH_ALIGN_CHECK_EN` not defined:
  - Redirect target used as given.
  - No FAULT state; `fetch_fault` is a constant 0.

## Test plan
- Reset release, memory always ready, 1-cycle response, `instr_ready = 1`:
  - First request addr 0x0040_0000.
  - `instr_pc` sequence 0x0040_0000, 0x0040_0004, 0x0040_0008.
- `instr_ready = 0` for 10 cycles:
  - Exactly 2 words queued.
  - `imem_req_valid` stays 0 after the second acceptance.
  - Release → words pop in order, with no loss or duplication.
- Redirect to 0x0040_0100 while a request is outstanding (response delayed 3 cycles):
  - Stale response discarded.
  - Next request addr 0x0040_0100.
  - First `instr_pc` after the redirect = 0x0040_0100.
- Redirect in the same cycle as a response and a consume:
  - Response dropped, queue empty the next cycle.
  - Next `instr_pc` = redirect target.
- `reset_n` pulsed low mid-stream:
  - Outputs return to their reset values asynchronously.
  - Fetch restarts at 0x0040_0000.
- With `FETCH_ALIGN_CHECK_EN`: redirect to 0x0040_0102 → `fetch_fault = 1` next cycle, no requests thereafter. Without the macro: the request addr is 0x0040_0102.
